// File: rtl/gcbp_subimage_write_seq.sv
// Walks each frame line by line and streams the 4x4 sub-image window pixels from the line buffer into BRAM.
// Optional macro GCBP_SEQ_OVERRUN_EN enables the sticky o_overrun flag for lines that arrive during a write.
module gcbp_subimage_write_seq #(
  parameter int SUB_W     = 32,
  parameter int SUB_H     = 32,
  parameter int V_START   = 16,
  parameter int H_START   = 0,
  parameter int IMG_LINES = 480
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_start,
  input  logic       i_line_done,
  output logic [9:0] o_lbuf_addr,
  output logic       o_gcbp_line_ready,
  output logic       o_valid_subimage_line,
  output logic [1:0] o_vert_subimage_cnt,
  output logic [1:0] o_hori_subimage_cnt,
  output logic [9:0] o_bram_addr,
  output logic       o_frame_done,
  output logic       o_overrun
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_LINE = 2'd1;
  localparam logic [1:0] WRITE     = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  localparam int PW     = (SUB_W > 1) ? $clog2(SUB_W) : 0;
  localparam int LINE_W = $clog2(IMG_LINES + 1);

  localparam logic [9:0]        PIX_LAST  = 10'(4 * SUB_W - 1);
  localparam logic [9:0]        PIX_MASK  = 10'(SUB_W - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMG_LINES - 1);
  localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);

  logic [1:0]        state_r;
  logic [LINE_W-1:0] line_r;
  logic [9:0]        pix_r;

  int   line_s;
  int   rel_s;
  logic in_window_s;
  logic [9:0] p_s;

  // pix_r runs 0..4*SUB_W-1, so hori*SUB_W+p is simply pix_r
  assign line_s      = int'(line_r);
  assign rel_s       = line_s - V_START;
  assign in_window_s = (line_s >= V_START) && (line_s < V_START + 4 * SUB_H);
  assign p_s         = pix_r & PIX_MASK;

  // Output decode: addresses and strobe are zero-latency from the write counters
  always_comb begin
    o_gcbp_line_ready     = 1'b0;
    o_lbuf_addr           = 10'd0;
    o_bram_addr           = 10'd0;
    o_hori_subimage_cnt   = 2'd0;
    o_valid_subimage_line = 1'b0;
    o_vert_subimage_cnt   = 2'd0;
    o_frame_done          = 1'b0;
    if (state_r != IDLE && in_window_s) begin
      o_valid_subimage_line = 1'b1;
      o_vert_subimage_cnt   = 2'(rel_s / SUB_H);
    end else begin
      o_valid_subimage_line = 1'b0;
    end
    case (state_r)
      WRITE: begin
        o_gcbp_line_ready   = 1'b1;
        o_lbuf_addr         = 10'(H_START + int'(pix_r));
        o_bram_addr         = 10'((rel_s % SUB_H) * SUB_W + int'(p_s));
        o_hori_subimage_cnt = pix_r[PW+1:PW];
      end
      DONE:    o_frame_done = 1'b1;
      default: o_frame_done = 1'b0;
    endcase
  end

  // Sequencer: frame_start aborts from anywhere and beats a same-cycle line_done
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      line_r  <= '0;
      pix_r   <= 10'd0;
    end else if (i_frame_start) begin
      state_r <= WAIT_LINE;
      line_r  <= '0;
      pix_r   <= 10'd0;
    end else begin
      case (state_r)
        IDLE: state_r <= IDLE;
        WAIT_LINE: begin
          if (i_line_done) begin
            if (in_window_s) begin
              state_r <= WRITE;
              pix_r   <= 10'd0;
            end else begin
              line_r  <= line_r + LINE_ONE;
              state_r <= (line_r == LINE_LAST) ? DONE : WAIT_LINE;
            end
          end
        end
        WRITE: begin
          if (pix_r == PIX_LAST) begin
            pix_r   <= 10'd0;
            line_r  <= line_r + LINE_ONE;
            state_r <= (line_r == LINE_LAST) ? DONE : WAIT_LINE;
          end else begin
            pix_r <= pix_r + 10'd1;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef GCBP_SEQ_OVERRUN_EN
  logic overrun_r;

  // Sticky overrun: a line arriving mid-write is lost, remember it until the next frame
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      overrun_r <= 1'b0;
    end else if (i_frame_start) begin
      overrun_r <= 1'b0;
    end else if (state_r == WRITE && i_line_done) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign o_overrun = overrun_r;
`else
  assign o_overrun = 1'b0;
`endif

endmodule
